// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
//
// Purpose:
//   Takes decoded memory operations from the execute stage and forms the
//   effective address. Drives a req/ack handshake toward the memory arbiter.
//   Runs the multi-word interrupt context push (INT_PUSH) as a burst of
//   PUSH_DEPTH write beats at base_sp + k.
//
// Optional feature (compile-time macro MEM_ACCESS_STACK_CHECK_EN):
//   When the macro is defined, SP-relative operations and INT_PUSH beats whose
//   address is below STACK_LIMIT are rejected. A rejected beat never issues,
//   o_fault pulses for one cycle and the block returns to IDLE.
//   When the macro is undefined, no check is made and o_fault is constant 0.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst              synchronous active-high reset
//   i_op_valid         operation offered
//   o_op_ready         block can accept an operation (IDLE only)
//   i_op_code          0 NONE, 1 LOAD_R, 2 LOAD_SP, 3 STORE_R, 4 STORE_SP,
//                      5 INT_PUSH, 6/7 treated as NONE
//   i_imm              raw immediate (R forms use [4:0], SP forms use [7:0])
//   i_base_r           general register base
//   i_base_sp          stack pointer base
//   i_store_data       write data for STORE_R / STORE_SP
//   i_push_data        burst words, word k at [k*DATA_W +: DATA_W]
//   i_flush            aborts any operation in progress
//   o_mem_req          memory request valid
//   i_mem_ack          memory accepted the current beat
//   o_memory_control   0 IDLE, 1 READ, 2 WRITE
//   o_memory_address   beat address
//   o_mem_wdata        beat write data, 0 on reads
//   o_op_done          one-cycle pulse when the last beat is acknowledged
//   o_fault            one-cycle pulse on a rejected access
// -----------------------------------------------------------------------------
module mem_access_sequencer #(
  parameter int                 ADDR_W      = 16,
  parameter int                 DATA_W      = 16,
  parameter int                 PUSH_DEPTH  = 3,
  parameter logic [ADDR_W-1:0]  STACK_LIMIT = 16'h8000
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_op_valid,
  output logic                         o_op_ready,
  input  logic [2:0]                   i_op_code,
  input  logic [7:0]                   i_imm,
  input  logic [ADDR_W-1:0]            i_base_r,
  input  logic [ADDR_W-1:0]            i_base_sp,
  input  logic [DATA_W-1:0]            i_store_data,
  input  logic [PUSH_DEPTH*DATA_W-1:0] i_push_data,
  input  logic                         i_flush,
  output logic                         o_mem_req,
  input  logic                         i_mem_ack,
  output logic [1:0]                   o_memory_control,
  output logic [ADDR_W-1:0]            o_memory_address,
  output logic [DATA_W-1:0]            o_mem_wdata,
  output logic                         o_op_done,
  output logic                         o_fault
);

  // Beat counter covers indices 0..7, the largest legal PUSH_DEPTH.
  localparam int                CNT_W     = 3;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(PUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0]  BEAT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONES = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_LOAD_R   = 3'd1;
  localparam logic [2:0] OP_LOAD_SP  = 3'd2;
  localparam logic [2:0] OP_STORE_R  = 3'd3;
  localparam logic [2:0] OP_STORE_SP = 3'd4;
  localparam logic [2:0] OP_INT_PUSH = 3'd5;

  localparam logic [1:0] CTRL_IDLE  = 2'd0;
  localparam logic [1:0] CTRL_READ  = 2'd1;
  localparam logic [1:0] CTRL_WRITE = 2'd2;

`ifdef MEM_ACCESS_STACK_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_BURST  = 2'd2
  } state_t;

  // Selects burst word k from a packed push-data vector.
  function automatic logic [DATA_W-1:0] push_word(
    input logic [PUSH_DEPTH*DATA_W-1:0] data,
    input logic [CNT_W-1:0]             idx
  );
    logic [DATA_W-1:0] word;
    word = {DATA_W{1'b0}};
    for (int i = 0; i < PUSH_DEPTH; i++) begin
      if (idx == CNT_W'(i)) begin
        word = data[i*DATA_W +: DATA_W];
      end
    end
    return word;
  endfunction

  // True when a stack-relative address must be rejected (constant 0 when the
  // check is compiled out).
  function automatic logic stack_violation(input logic [ADDR_W-1:0] addr);
    return CHECK_EN && (addr < STACK_LIMIT);
  endfunction

  // Registers
  state_t                       r_state;
  logic [CNT_W-1:0]             r_beat;
  logic [PUSH_DEPTH*DATA_W-1:0] r_push_data;
  logic                         r_mem_req;
  logic [1:0]                   r_mem_ctrl;
  logic [ADDR_W-1:0]            r_mem_addr;
  logic [DATA_W-1:0]            r_mem_wdata;
  logic                         r_op_done;
  logic                         r_fault;

  // Next-state values
  state_t                       w_state_nxt;
  logic [CNT_W-1:0]             w_beat_nxt;
  logic [PUSH_DEPTH*DATA_W-1:0] w_push_data_nxt;
  logic                         w_mem_req_nxt;
  logic [1:0]                   w_mem_ctrl_nxt;
  logic [ADDR_W-1:0]            w_mem_addr_nxt;
  logic [DATA_W-1:0]            w_mem_wdata_nxt;
  logic                         w_op_done_nxt;
  logic                         w_fault_nxt;

  // Decoded view of the offered operation
  logic                         w_dec_go;
  logic                         w_dec_sp;
  logic                         w_dec_burst;
  logic [1:0]                   w_dec_ctrl;
  logic [ADDR_W-1:0]            w_dec_addr;
  logic [DATA_W-1:0]            w_dec_wdata;

  logic [ADDR_W-1:0]            w_sext5;
  logic [ADDR_W-1:0]            w_sext8;
  logic [ADDR_W-1:0]            w_burst_addr;
  logic [CNT_W-1:0]             w_beat_inc;

  assign w_sext5      = {{(ADDR_W-5){i_imm[4]}}, i_imm[4:0]};
  assign w_sext8      = {{(ADDR_W-8){i_imm[7]}}, i_imm[7:0]};
  assign w_burst_addr = r_mem_addr + ADDR_ONE;
  assign w_beat_inc   = r_beat + BEAT_ONE;

  assign o_op_ready       = (r_state == ST_IDLE);
  assign o_mem_req        = r_mem_req;
  assign o_memory_control = r_mem_ctrl;
  assign o_memory_address = r_mem_addr;
  assign o_mem_wdata      = r_mem_wdata;
  assign o_op_done        = r_op_done;
  assign o_fault          = r_fault;

  // Decode the offered op code into first-beat address, control and data.
  always_comb begin
    w_dec_go    = 1'b0;
    w_dec_sp    = 1'b0;
    w_dec_burst = 1'b0;
    w_dec_ctrl  = CTRL_IDLE;
    w_dec_addr  = ADDR_ONES;
    w_dec_wdata = {DATA_W{1'b0}};
    case (i_op_code)
      OP_LOAD_R: begin
        w_dec_go   = 1'b1;
        w_dec_ctrl = CTRL_READ;
        w_dec_addr = i_base_r + w_sext5;
      end
      OP_LOAD_SP: begin
        w_dec_go   = 1'b1;
        w_dec_sp   = 1'b1;
        w_dec_ctrl = CTRL_READ;
        w_dec_addr = i_base_sp + w_sext8;
      end
      OP_STORE_R: begin
        w_dec_go    = 1'b1;
        w_dec_ctrl  = CTRL_WRITE;
        w_dec_addr  = i_base_r + w_sext5;
        w_dec_wdata = i_store_data;
      end
      OP_STORE_SP: begin
        w_dec_go    = 1'b1;
        w_dec_sp    = 1'b1;
        w_dec_ctrl  = CTRL_WRITE;
        w_dec_addr  = i_base_sp + w_sext8;
        w_dec_wdata = i_store_data;
      end
      OP_INT_PUSH: begin
        w_dec_go    = 1'b1;
        w_dec_sp    = 1'b1;
        w_dec_burst = 1'b1;
        w_dec_ctrl  = CTRL_WRITE;
        w_dec_addr  = i_base_sp;
        w_dec_wdata = i_push_data[DATA_W-1:0];
      end
      default: begin
        // NONE and the unused codes 6/7 are accepted as no-ops.
        w_dec_go    = 1'b0;
        w_dec_sp    = 1'b0;
        w_dec_burst = 1'b0;
        w_dec_ctrl  = CTRL_IDLE;
        w_dec_addr  = ADDR_ONES;
        w_dec_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat;
    w_push_data_nxt = r_push_data;
    w_mem_req_nxt   = r_mem_req;
    w_mem_ctrl_nxt  = r_mem_ctrl;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_op_done_nxt   = 1'b0;
    w_fault_nxt     = 1'b0;

    if (i_flush) begin
      // Flush outranks ack and a new offer: drop everything silently.
      w_state_nxt     = ST_IDLE;
      w_beat_nxt      = {CNT_W{1'b0}};
      w_mem_req_nxt   = 1'b0;
      w_mem_ctrl_nxt  = CTRL_IDLE;
      w_mem_addr_nxt  = ADDR_ONES;
      w_mem_wdata_nxt = {DATA_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_op_valid && w_dec_go) begin
            if (w_dec_sp && stack_violation(w_dec_addr)) begin
              w_fault_nxt = 1'b1;
            end else begin
              w_state_nxt     = w_dec_burst ? ST_BURST : ST_SINGLE;
              w_beat_nxt      = {CNT_W{1'b0}};
              w_push_data_nxt = i_push_data;
              w_mem_req_nxt   = 1'b1;
              w_mem_ctrl_nxt  = w_dec_ctrl;
              w_mem_addr_nxt  = w_dec_addr;
              w_mem_wdata_nxt = w_dec_wdata;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_SINGLE: begin
          if (r_mem_req && i_mem_ack) begin
            w_state_nxt     = ST_IDLE;
            w_mem_req_nxt   = 1'b0;
            w_mem_ctrl_nxt  = CTRL_IDLE;
            w_mem_addr_nxt  = ADDR_ONES;
            w_mem_wdata_nxt = {DATA_W{1'b0}};
            w_op_done_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_SINGLE;
          end
        end
        ST_BURST: begin
          if (r_mem_req && i_mem_ack) begin
            if (r_beat == LAST_BEAT) begin
              w_state_nxt     = ST_IDLE;
              w_beat_nxt      = {CNT_W{1'b0}};
              w_mem_req_nxt   = 1'b0;
              w_mem_ctrl_nxt  = CTRL_IDLE;
              w_mem_addr_nxt  = ADDR_ONES;
              w_mem_wdata_nxt = {DATA_W{1'b0}};
              w_op_done_nxt   = 1'b1;
            end else if (stack_violation(w_burst_addr)) begin
              // Earlier beats stay written; only the offending beat is held back.
              w_state_nxt     = ST_IDLE;
              w_beat_nxt      = {CNT_W{1'b0}};
              w_mem_req_nxt   = 1'b0;
              w_mem_ctrl_nxt  = CTRL_IDLE;
              w_mem_addr_nxt  = ADDR_ONES;
              w_mem_wdata_nxt = {DATA_W{1'b0}};
              w_fault_nxt     = 1'b1;
            end else begin
              // Next beat follows with no request bubble.
              w_beat_nxt      = w_beat_inc;
              w_mem_addr_nxt  = w_burst_addr;
              w_mem_wdata_nxt = push_word(r_push_data, w_beat_inc);
            end
          end else begin
            w_state_nxt = ST_BURST;
          end
        end
        default: begin
          w_state_nxt     = ST_IDLE;
          w_beat_nxt      = {CNT_W{1'b0}};
          w_mem_req_nxt   = 1'b0;
          w_mem_ctrl_nxt  = CTRL_IDLE;
          w_mem_addr_nxt  = ADDR_ONES;
          w_mem_wdata_nxt = {DATA_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= {CNT_W{1'b0}};
      r_push_data <= {(PUSH_DEPTH*DATA_W){1'b0}};
      r_mem_req   <= 1'b0;
      r_mem_ctrl  <= CTRL_IDLE;
      r_mem_addr  <= ADDR_ONES;
      r_mem_wdata <= {DATA_W{1'b0}};
      r_op_done   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_push_data <= w_push_data_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_ctrl  <= w_mem_ctrl_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_op_done   <= w_op_done_nxt;
      r_fault     <= w_fault_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sequencer
//
// Self-checking bench for mem_access_sequencer (default parameters).
// Expected beats are pushed to a scoreboard queue when an operation is
// offered and popped when the DUT presents the beat. Outputs are sampled
// 1 time unit after the rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [15:0] addr;
    logic [15:0] wdata;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_code;
  logic [7:0]  imm;
  logic [15:0] base_r;
  logic [15:0] base_sp;
  logic [15:0] store_data;
  logic [47:0] push_data;
  logic        flush;
  logic        mem_req;
  logic        mem_ack;
  logic [1:0]  memory_control;
  logic [15:0] memory_address;
  logic [15:0] mem_wdata;
  logic        op_done;
  logic        fault;

  beat_t sb_q[$];
  int    n_cmp;
  int    n_err;

  mem_access_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_op_valid       (op_valid),
    .o_op_ready       (op_ready),
    .i_op_code        (op_code),
    .i_imm            (imm),
    .i_base_r         (base_r),
    .i_base_sp        (base_sp),
    .i_store_data     (store_data),
    .i_push_data      (push_data),
    .i_flush          (flush),
    .o_mem_req        (mem_req),
    .i_mem_ack        (mem_ack),
    .o_memory_control (memory_control),
    .o_memory_address (memory_address),
    .o_mem_wdata      (mem_wdata),
    .o_op_done        (op_done),
    .o_fault          (fault)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"},   32'(mem_req),        32'd0);
    check_eq({tag, "_ctrl"},  32'(memory_control), 32'd0);
    check_eq({tag, "_addr"},  32'(memory_address), 32'h0000FFFF);
    check_eq({tag, "_wdata"}, 32'(mem_wdata),      32'd0);
    check_eq({tag, "_ready"}, 32'(op_ready),       32'd1);
  endtask

  task automatic check_beat(input string tag, input beat_t e);
    check_eq({tag, "_req"},   32'(mem_req),        32'd1);
    check_eq({tag, "_ctrl"},  32'(memory_control), 32'(e.ctrl));
    check_eq({tag, "_addr"},  32'(memory_address), 32'(e.addr));
    check_eq({tag, "_wdata"}, 32'(mem_wdata),      32'(e.wdata));
    check_eq({tag, "_ready"}, 32'(op_ready),       32'd0);
    check_eq({tag, "_done"},  32'(op_done),        32'd0);
  endtask

  // Offer one operation for a single edge and enqueue the beats it must produce.
  task automatic issue_op(input logic [2:0] code, input logic [7:0] im, input logic [15:0] br,
                          input logic [15:0] bsp, input logic [15:0] sd, input logic [47:0] pd);
    beat_t b;
    check_eq("ready_at_issue", 32'(op_ready), 32'd1);
    op_valid   = 1'b1;
    op_code    = code;
    imm        = im;
    base_r     = br;
    base_sp    = bsp;
    store_data = sd;
    push_data  = pd;
    case (code)
      3'd1, 3'd3: begin
        b.addr  = br + {{11{im[4]}}, im[4:0]};
        b.ctrl  = (code == 3'd1) ? 2'd1 : 2'd2;
        b.wdata = (code == 3'd1) ? 16'h0000 : sd;
        sb_q.push_back(b);
      end
      3'd2, 3'd4: begin
        b.addr  = bsp + {{8{im[7]}}, im};
        b.ctrl  = (code == 3'd2) ? 2'd1 : 2'd2;
        b.wdata = (code == 3'd2) ? 16'h0000 : sd;
        sb_q.push_back(b);
      end
      3'd5: begin
        for (int k = 0; k < 3; k++) begin
          b.addr  = bsp + 16'(k);
          b.ctrl  = 2'd2;
          b.wdata = pd[k*16 +: 16];
          sb_q.push_back(b);
        end
      end
      default: begin
      end
    endcase
    step();
    // Scramble operands so any late sampling by the DUT shows up.
    op_valid   = 1'b0;
    op_code    = 3'($urandom);
    imm        = 8'($urandom);
    base_r     = 16'($urandom);
    base_sp    = 16'($urandom);
    store_data = 16'($urandom);
    push_data  = {16'($urandom), 32'($urandom)};
  endtask

  // Serve n beats, holding ack low for dly cycles before each ack.
  task automatic serve(input int n, input int dly);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        return;
      end
      e = sb_q.pop_front();
      for (int d = 0; d < dly; d++) begin
        check_beat("hold", e);
        step();
      end
      check_beat("beat", e);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    check_eq("done_pulse", 32'(op_done), 32'd1);
    check_idle_outputs("after_done");
    step();
    check_eq("done_cleared", 32'(op_done), 32'd0);
  endtask

  initial begin
    beat_t e;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    op_valid   = 1'b0;
    op_code    = 3'd0;
    imm        = 8'h00;
    base_r     = 16'h0000;
    base_sp    = 16'h0000;
    store_data = 16'h0000;
    push_data  = 48'h0;
    flush      = 1'b0;
    mem_ack    = 1'b0;

    // Reset state
    step();
    step();
    check_idle_outputs("reset");
    check_eq("reset_done",  32'(op_done), 32'd0);
    check_eq("reset_fault", 32'(fault),   32'd0);
    rst = 1'b0;
    check_eq("ready_after_reset", 32'(op_ready), 32'd1);

    // LOAD_R with negative 5-bit immediate, ack after 3 hold cycles
    issue_op(3'd1, 8'hFE, 16'h0010, 16'h1111, 16'h2222, 48'h0);
    check_eq("loadr_addr", 32'(memory_address), 32'h0000000E);
    serve(1, 3);

    // STORE_SP wrapping past the top of memory
    issue_op(3'd4, 8'h02, 16'h3333, 16'hFFFF, 16'hBEEF, 48'h0);
    check_eq("storesp_addr", 32'(memory_address), 32'h00000001);
    serve(1, 1);

    // STORE_R with positive immediate; upper imm bits must be ignored
    issue_op(3'd3, 8'hE5, 16'h1000, 16'h0000, 16'hCAFE, 48'h0);
    serve(1, 0);

    // INT_PUSH with ack held high: three back-to-back beats
    issue_op(3'd5, 8'h00, 16'h0000, 16'h9000, 16'h0000, {16'hA222, 16'hA111, 16'hA000});
    serve(3, 0);

    // INT_PUSH with flush arriving together with the second ack
    issue_op(3'd5, 8'h00, 16'h0000, 16'h9000, 16'h0000, {16'hB222, 16'hB111, 16'hB000});
    e = sb_q.pop_front();
    check_beat("flush_b0", e);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    e = sb_q.pop_front();
    check_beat("flush_b1", e);
    mem_ack = 1'b1;
    flush   = 1'b1;
    step();
    mem_ack = 1'b0;
    flush   = 1'b0;
    sb_q.delete();
    check_idle_outputs("flushed");
    check_eq("flush_no_done", 32'(op_done), 32'd0);
    check_eq("flush_no_fault", 32'(fault), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("flush_no_beat2", 32'(mem_req), 32'd0);
      check_eq("flush_done_low", 32'(op_done), 32'd0);
    end

    // op_valid while busy must be ignored
    issue_op(3'd1, 8'h01, 16'h1234, 16'h0000, 16'h0000, 48'h0);
    op_valid = 1'b1;
    op_code  = 3'd3;
    base_r   = 16'h5555;
    imm      = 8'h07;
    for (int i = 0; i < 3; i++) begin
      check_beat("busy_offer", sb_q[0]);
      step();
    end
    op_valid = 1'b0;
    serve(1, 0);

    // mem_ack while idle must be ignored
    mem_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_idle_outputs("idle_ack");
      check_eq("idle_ack_done", 32'(op_done), 32'd0);
    end
    mem_ack = 1'b0;

    // NONE and unused op codes are no-ops
    issue_op(3'd0, 8'h01, 16'h1000, 16'h2000, 16'h0000, 48'h0);
    check_idle_outputs("op_none");
    check_eq("op_none_done", 32'(op_done), 32'd0);
    issue_op(3'd7, 8'h01, 16'h1000, 16'h2000, 16'h0000, 48'h0);
    check_idle_outputs("op_seven");
    check_eq("op_seven_done", 32'(op_done), 32'd0);

    // Reset in the middle of an operation
    issue_op(3'd3, 8'h03, 16'h4000, 16'h0000, 16'h1234, 48'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_q.delete();
    check_idle_outputs("mid_reset");
    check_eq("mid_reset_done", 32'(op_done), 32'd0);

    // LOAD_SP just below the stack limit
`ifdef MEM_ACCESS_STACK_CHECK_EN
    op_valid = 1'b1;
    op_code  = 3'd2;
    imm      = 8'hFE;
    base_sp  = 16'h8001;
    step();
    op_valid = 1'b0;
    check_eq("stack_fault", 32'(fault), 32'd1);
    check_idle_outputs("stack_reject");
    step();
    check_eq("stack_fault_pulse", 32'(fault), 32'd0);
    check_eq("stack_no_req", 32'(mem_req), 32'd0);
    check_eq("stack_no_done", 32'(op_done), 32'd0);
`else
    issue_op(3'd2, 8'hFE, 16'h0000, 16'h8001, 16'h0000, 48'h0);
    check_eq("stack_addr", 32'(memory_address), 32'h00007FFF);
    check_eq("stack_no_fault", 32'(fault), 32'd0);
    serve(1, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
